// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner.
//   SEG_BLANK_CODE : digit code the downstream decoder renders as all segments off.
//   scan_state_e   : scanner phase, GUARD (all anodes off) or SHOW (one digit lit).
//   lz_blank_mask  : per-digit leading-zero blank mask for a packed BCD value.
package seg_pkg;

  localparam int unsigned MAX_DIGITS = 8;
  localparam logic [3:0]  SEG_BLANK_CODE = 4'hF;

  typedef enum logic [0:0] {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  // Bit i is set when digit i and every digit above it (up to num_digits-1) is zero.
  // Digit 0 is never blanked so an all-zero value still shows a single "0".
  function automatic logic [MAX_DIGITS-1:0] lz_blank_mask(
    input logic [4*MAX_DIGITS-1:0] value,
    input int                      num_digits
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  all_zero;
    mask     = '0;
    all_zero = 1'b1;
    for (int i = int'(MAX_DIGITS) - 1; i >= 1; i--) begin
      if (i < num_digits) begin
        all_zero = all_zero & (value[4*i +: 4] == 4'h0);
        mask[i]  = all_zero;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Bus between the display owner (master) and the digit scanner (slave).
//   VALUE      : packed BCD digits, digit 0 in [3:0].
//   LOAD       : one-cycle strobe capturing VALUE into the pending register.
//   BLANK_LZ   : blank leading zero digits.
//   DP_IN      : per-digit decimal-point request.
//   D          : digit code to the registered decoder (4'hF = blank).
//   DP         : decimal point, aligned with AN.
//   AN         : anode enables, aligned with the decoder's registered output.
//   FRAME_DONE : one-cycle pulse when the last digit's slot ends.
interface seg_scan_mux_if #(
  parameter int unsigned NUM_DIGITS = 4
) ();
  import seg_pkg::*;

  logic [4*NUM_DIGITS-1:0] VALUE;
  logic                    LOAD;
  logic                    BLANK_LZ;
  logic [NUM_DIGITS-1:0]   DP_IN;
  logic [3:0]              D;
  logic                    DP;
  logic [NUM_DIGITS-1:0]   AN;
  logic                    FRAME_DONE;

  modport master (
    output VALUE, LOAD, BLANK_LZ, DP_IN,
    input  D, DP, AN, FRAME_DONE
  );

  modport slave (
    input  VALUE, LOAD, BLANK_LZ, DP_IN,
    output D, DP, AN, FRAME_DONE
  );

endinterface

// File: rtl/seg_tick_counter.sv
// Free-running tick counter with a per-cycle terminal value.
//   clk_i  : clock.
//   rst_i  : asynchronous active-high reset, count returns to 0.
//   clr_i  : synchronous clear (takes priority over counting).
//   term_i : terminal count, reloaded by the owner for each scan phase.
//   tc_o   : high while the count equals term_i.
module seg_tick_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [Width-1:0] term_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q + 1'b1;
    tc_o  = (cnt_q == term_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed display scanner feeding a registered 7-segment decoder.
// Time-slices a NUM_DIGITS BCD value onto D with an all-off guard interval between
// digits. AN and DP run one register stage behind D so each lit anode coincides with
// the decoder's registered segment output for that digit.
//   CLK, RST : clock and asynchronous active-high reset.
//   bus      : slave side of seg_scan_mux_if (VALUE/LOAD/BLANK_LZ/DP_IN in,
//              D/DP/AN/FRAME_DONE out).
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS      = 4,
  parameter int unsigned TICKS_PER_DIGIT = 50000,
  parameter int unsigned GUARD_TICKS     = 500,
  parameter bit          AN_ACTIVE_LOW   = 1'b1
) (
  input logic            CLK,
  input logic            RST,
  seg_scan_mux_if.slave  bus
);

  localparam int unsigned IdxW     = $clog2(NUM_DIGITS);
  localparam int unsigned MaxTicks = (TICKS_PER_DIGIT > GUARD_TICKS) ? TICKS_PER_DIGIT
                                                                      : GUARD_TICKS;
  localparam int unsigned CntW     = (MaxTicks > 2) ? $clog2(MaxTicks) : 1;

  localparam logic [IdxW-1:0]       LastIdx   = IdxW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AnOff     = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;
  localparam logic [CntW-1:0]       GuardTerm = CntW'(GUARD_TICKS - 1);
  localparam logic [CntW-1:0]       ShowTerm  = CntW'(TICKS_PER_DIGIT - 1);

  scan_state_e             state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [3:0]              code_q, code_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q, frame_done_d;

  logic                    tc;
  logic [CntW-1:0]         term;
  logic                    wrap;
  logic [4*MAX_DIGITS-1:0] active_ext;
  logic [MAX_DIGITS-1:0]   lz_mask;
  logic [3:0]              cur_digit;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   onehot;

  // One counter serves both phases; it restarts whenever the current phase terminates.
  assign term = (state_q == GUARD) ? GuardTerm : ShowTerm;

  seg_tick_counter #(
    .Width (CntW)
  ) u_tick (
    .clk_i  (CLK),
    .rst_i  (RST),
    .clr_i  (tc),
    .term_i (term),
    .tc_o   (tc)
  );

  always_comb begin
    active_ext                   = '0;
    active_ext[4*NUM_DIGITS-1:0] = active_q;
    lz_mask                      = lz_blank_mask(active_ext, int'(NUM_DIGITS));
    cur_digit                    = active_q[4*idx_q +: 4];
    cur_blank                    = bus.BLANK_LZ & lz_mask[idx_q];
    onehot                       = NUM_DIGITS'(1) << idx_q;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wrap         = 1'b0;
    pending_d    = bus.LOAD ? bus.VALUE : pending_q;
    active_d     = active_q;

    case (state_q)
      GUARD: begin
        if (tc) state_d = SHOW;
      end
      SHOW: begin
        if (tc) begin
          state_d = GUARD;
          if (idx_q == LastIdx) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = GUARD;
    endcase

    // Frame boundary: pending_q (not VALUE) moves over, so a coincident LOAD waits a frame.
    if (wrap) active_d = pending_q;
    frame_done_d = wrap;

    // D follows the next state. Whenever state_d is SHOW, idx_d equals idx_q, so the
    // current-index digit is the right one.
    code_d = SEG_BLANK_CODE;
    if (state_d == SHOW) code_d = cur_blank ? SEG_BLANK_CODE : cur_digit;

    // AN/DP follow the current state, i.e. one cycle behind D.
    an_d = AnOff;
    dp_d = 1'b0;
    if (state_q == SHOW) begin
      an_d = AnOff ^ onehot;
      dp_d = bus.DP_IN[idx_q];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= GUARD;
      idx_q        <= '0;
      pending_q    <= '0;
      active_q     <= '0;
      code_q       <= SEG_BLANK_CODE;
      an_q         <= AnOff;
      dp_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      active_q     <= active_d;
      code_q       <= code_d;
      an_q         <= an_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.D          = code_q;
  assign bus.DP         = dp_q;
  assign bus.AN         = an_q;
  assign bus.FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with NUM_DIGITS=4, TICKS_PER_DIGIT=4, GUARD_TICKS=2,
// active-low anodes. A frame is 4 * (4 + 2) = 24 cycles; outputs are sampled on the
// falling edge and inputs are driven there too.
module tb_seg_scan_mux;

  localparam int unsigned NDig  = 4;
  localparam int unsigned Ticks = 4;
  localparam int unsigned Guard = 2;
  localparam int          Slot  = Ticks + Guard;
  localparam int          Frame = NDig * Slot;

  logic clk;
  logic rst;

  seg_scan_mux_if #(.NUM_DIGITS(NDig)) bus ();

  seg_scan_mux #(
    .NUM_DIGITS      (NDig),
    .TICKS_PER_DIGIT (Ticks),
    .GUARD_TICKS     (Guard),
    .AN_ACTIVE_LOW   (1'b1)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] value;
    logic        blank_lz;
    logic [3:0]  dp_in;
    logic [15:0] exp_d;   // hand-computed D per digit, digit 0 in [3:0]
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Advance to the falling edge on which FRAME_DONE is high (start of a frame).
  task automatic sync_frame();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 3 * Frame; i++) begin
      if (bus.FRAME_DONE === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("frame_sync", {31'd0, found}, 32'd1);
  endtask

  // Check one full frame cycle by cycle, starting on the FRAME_DONE cycle. Optionally
  // pulses LOAD with load_val right after cycle load_at. Returns at the next frame start.
  task automatic check_frame(input logic [15:0] exp_d, input logic [3:0] dp_mask,
                             input int load_at, input logic [15:0] load_val);
    for (int k = 0; k < Frame; k++) begin
      int         s;
      int         p;
      int         on_dig;
      logic [3:0] ed;
      logic [3:0] ean;
      logic       edp;
      s      = k / Slot;
      p      = k % Slot;
      ed     = (p >= Guard) ? exp_d[4*s +: 4] : 4'hF;
      on_dig = (p > Guard) ? s : ((p == 0) ? (s + NDig - 1) % NDig : -1);
      ean    = 4'hF;
      edp    = 1'b0;
      if (on_dig >= 0) begin
        ean[on_dig] = 1'b0;
        edp         = dp_mask[on_dig];
      end
      chk($sformatf("D[k=%0d]", k), {28'd0, bus.D}, {28'd0, ed});
      chk($sformatf("AN[k=%0d]", k), {28'd0, bus.AN}, {28'd0, ean});
      chk($sformatf("DP[k=%0d]", k), {31'd0, bus.DP}, {31'd0, edp});
      chk($sformatf("FRAME_DONE[k=%0d]", k), {31'd0, bus.FRAME_DONE}, {31'd0, k == 0});
      if (k == load_at) begin
        bus.VALUE = load_val;
        bus.LOAD  = 1'b1;
      end
      @(negedge clk);
      bus.LOAD = 1'b0;
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    bus.VALUE = v;
    bus.LOAD  = 1'b1;
    @(negedge clk);
    bus.LOAD  = 1'b0;
  endtask

  // After reset release: AN stays off for GUARD_TICKS posedges, digit 0 lights on the next.
  task automatic check_restart();
    repeat (Guard) @(negedge clk);
    chk("restart_an_off", {28'd0, bus.AN}, 32'hF);
    chk("restart_d0", {28'd0, bus.D}, 32'h0);
    @(negedge clk);
    chk("restart_an_bit0", {28'd0, bus.AN}, 32'hE);
    chk("restart_d0_held", {28'd0, bus.D}, 32'h0);
  endtask

  initial begin
    vecs[0] = '{value: 16'h1234, blank_lz: 1'b0, dp_in: 4'b0000, exp_d: 16'h1234};
    vecs[1] = '{value: 16'h0040, blank_lz: 1'b1, dp_in: 4'b0100, exp_d: 16'hFF40};
    vecs[2] = '{value: 16'h0000, blank_lz: 1'b1, dp_in: 4'b0001, exp_d: 16'hFFF0};
    vecs[3] = '{value: 16'h0040, blank_lz: 1'b0, dp_in: 4'b1111, exp_d: 16'h0040};
    vecs[4] = '{value: 16'h0A0C, blank_lz: 1'b1, dp_in: 4'b1010, exp_d: 16'hFA0C};
    vecs[5] = '{value: 16'h00E0, blank_lz: 1'b1, dp_in: 4'b0000, exp_d: 16'hFFE0};
    vecs[6] = '{value: 16'h1000, blank_lz: 1'b1, dp_in: 4'b1000, exp_d: 16'h1000};

    rst          = 1'b1;
    bus.VALUE    = '0;
    bus.LOAD     = 1'b0;
    bus.BLANK_LZ = 1'b0;
    bus.DP_IN    = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_an", {28'd0, bus.AN}, 32'hF);
    chk("rst_d", {28'd0, bus.D}, 32'hF);
    chk("rst_frame_done", {31'd0, bus.FRAME_DONE}, 32'd0);
    chk("rst_dp", {31'd0, bus.DP}, 32'd0);
    rst = 1'b0;
    check_restart();

    // Table-driven frames. Two frame starts are skipped so a LOAD coinciding with a
    // wrap still has the new value active in the checked frame.
    foreach (vecs[i]) begin
      bus.BLANK_LZ = vecs[i].blank_lz;
      bus.DP_IN    = vecs[i].dp_in;
      pulse_load(vecs[i].value);
      sync_frame();
      @(negedge clk);
      sync_frame();
      check_frame(vecs[i].exp_d, vecs[i].dp_in, -1, 16'h0);
    end

    // Tear-free update: LOAD mid-frame while 1234 is shown.
    bus.BLANK_LZ = 1'b0;
    bus.DP_IN    = 4'b0100;
    pulse_load(16'h1234);
    sync_frame();
    @(negedge clk);
    sync_frame();
    check_frame(16'h1234, 4'b0100, 8, 16'h5678);
    check_frame(16'h5678, 4'b0100, -1, 16'h0);

    // LOAD on the wrap edge: active keeps the previous pending for one more frame.
    check_frame(16'h5678, 4'b0100, Frame - 1, 16'h9012);
    check_frame(16'h5678, 4'b0100, -1, 16'h0);
    check_frame(16'h9012, 4'b0100, -1, 16'h0);

    // Mid-scan reset while digit 2 is lit.
    repeat (2 * Slot + Guard + 2) @(negedge clk);
    chk("pre_rst_an2", {28'd0, bus.AN}, 32'hB);
    chk("pre_rst_dp", {31'd0, bus.DP}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_an", {28'd0, bus.AN}, 32'hF);
    chk("midrst_d", {28'd0, bus.D}, 32'hF);
    chk("midrst_dp", {31'd0, bus.DP}, 32'd0);
    chk("midrst_frame_done", {31'd0, bus.FRAME_DONE}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_restart();
    // pending was cleared too, so frames keep showing zero until a new LOAD.
    sync_frame();
    check_frame(16'h0000, 4'b0100, -1, 16'h0);
    check_frame(16'h0000, 4'b0100, 3, 16'h4321);
    check_frame(16'h4321, 4'b0100, -1, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Multiplexed display scanner sitting directly upstream of the registered 7-segment decoder.
- Holds a NUM_DIGITS-digit BCD value and time-slices it one digit at a time onto the decoder's 4-bit input.
- Drives the digit anode enables one cycle late, so each enable lines up with the decoder's registered SEG output.
- Inserts an all-off guard interval between digits to suppress ghosting, and optionally blanks leading zeros.

Parameters:
- NUM_DIGITS, 4: digits scanned, range 2..8.
- TICKS_PER_DIGIT, 50000: CLK cycles each digit is shown, must be >= 2.
- GUARD_TICKS, 500: CLK cycles with all anodes off between digits, must be >= 1.
- AN_ACTIVE_LOW, 1: 1 = an anode is enabled by driving 0; 0 = enabled by driving 1.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous, active-high reset.
- VALUE  input  4*NUM_DIGITS  BCD digits; digit 0 in [3:0] is the least significant.
- LOAD  input  1  single-cycle strobe that captures VALUE into the pending register.
- BLANK_LZ  input  1  1 = blank leading zero digits.
- DP_IN  input  NUM_DIGITS  per-digit decimal-point request, bit i for digit i.
- D  output  4  digit code to the decoder; 4'hF is the blank code.
- DP  output  1  decimal point for the current digit, active-high, aligned with AN.
- AN  output  NUM_DIGITS  anode enables, aligned with the decoder's SEG output.
- FRAME_DONE  output  1  one-cycle pulse when the last digit's slot ends.

Behaviour:
- Reset values (asynchronous, from RST high):
  - D = 4'hF.
  - DP = 0.
  - AN = all disabled (all 1s if AN_ACTIVE_LOW, else all 0s).
  - FRAME_DONE = 0.
  - pending and active registers = 0.
  - digit index = 0, tick counter = 0, state = GUARD.
- Register loading:
  - On LOAD high, VALUE is captured into pending on that edge.
  - pending is copied to active only at a frame boundary, i.e. when the index wraps from NUM_DIGITS-1 to 0. Frames therefore never tear.
  - If LOAD is asserted on the same edge as the wrap, active takes the previous pending value and the new VALUE lands in pending for the next frame.
- State machine with states GUARD and SHOW; a single tick counter is shared by both.
  - GUARD: all anodes off, D = 4'hF. When the counter reaches GUARD_TICKS-1, the counter clears and the state moves to SHOW.
  - SHOW: D = the active digit at the current index, or 4'hF if that digit is blanked. When the counter reaches TICKS_PER_DIGIT-1, the counter clears, the state moves to GUARD, and the index advances.
  - Index advance: the index increments, wrapping from NUM_DIGITS-1 to 0.
  - FRAME_DONE pulses for one cycle on the same edge the index wraps.
- Leading-zero blanking:
  - With BLANK_LZ = 1, digit i is blanked when it and every higher digit in active equal 0.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - BLANK_LZ is sampled combinationally each cycle.
- Non-BCD nibbles (10..14) pass through unchanged on D; the decoder renders them blank.
- Output timing:
  - D is registered.
  - AN and DP are registered one extra stage behind D, i.e. one cycle after the corresponding D value.
  - Consequence: the first SHOW cycle of a digit has AN still off, and AN stays enabled for one cycle into the following GUARD.
  - Each enabled AN cycle therefore coincides with a valid SEG for that digit.
- DP gating: DP = DP_IN[index], sampled in the SHOW cycle and delayed with AN; DP is forced to 0 whenever AN is all-off.
- Active anode: when enabled, AN has exactly one bit active, bit index; it is never one-hot for two digits simultaneously.
- Reset mid-scan: the block returns immediately to reset values, and after release scanning restarts at GUARD with index 0.

Decomposition:
- Shared package seg_pkg, holding:
  - SEG_BLANK_CODE = 4'hF.
  - the scan state enum {GUARD, SHOW}.
  - a function that returns the leading-zero blank mask for a given digit count.
- One sub-module is natural: seg_tick_counter, a loadable terminal-count counter with a clear input and a terminal-count output, instantiated once and reloaded per state.
- The decoder itself is instantiated by the parent, not inside this block.

Test Plan:
- Reset: hold RST for 3 cycles -> AN = 4'b1111, D = 4'hF, FRAME_DONE = 0. Release -> first AN low occurs GUARD_TICKS+1 cycles later, on bit 0.
- Basic scan: NUM_DIGITS=4, TICKS_PER_DIGIT=4, GUARD_TICKS=2, LOAD VALUE=16'h1234, wait one frame -> D sequence 4,3,2,1. AN bits 0,1,2,3 each active 4 cycles, trailing D by 1. FRAME_DONE pulses every 24 cycles.
- Tear-free update: LOAD 16'h5678 mid-frame while showing 16'h1234 -> the remaining digits of that frame still show 3,2,1; the next frame shows 8,7,6,5.
- Leading-zero blanking: VALUE=16'h0040, BLANK_LZ=1 -> D = 0,4,F,F. With VALUE=16'h0000 -> D = 0,F,F,F. With BLANK_LZ=0 -> all digits shown.
- Decimal point: DP_IN=4'b0100 -> DP high only while AN[2] is active, and low during all guard cycles.
- Mid-scan reset: assert RST while digit 2 is in SHOW -> AN all off within the same cycle. After release, the scan restarts at digit 0 and active = 0 until the next LOAD plus a wrap.
